// File: rtl/cr_axi4s_slv_mc.sv
// cr_axi4s_slv_mc: per-channel AXI4-Stream ingress FIFOs merged onto one output
// by a packet-granular round-robin arbiter, with optional store-and-forward.
module cr_axi4s_slv_mc #(
  parameter int N_CH = 4,
  parameter int DATA_W = 64,
  parameter int USER_W = 8,
  parameter int DEPTH = 16,
  parameter int AFULL_VAL = 2,
  parameter int AEMPTY_VAL = 1,
  parameter bit STORE_FWD = 1'b0,
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_tvalid,
  output logic [N_CH-1:0]        in_tready,
  input  logic [N_CH*DATA_W-1:0] in_tdata,
  input  logic [N_CH*USER_W-1:0] in_tuser,
  input  logic [N_CH-1:0]        in_tlast,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [DATA_W-1:0]      out_tdata,
  output logic [USER_W-1:0]      out_tuser,
  output logic                   out_tlast,
  output logic [ID_W-1:0]        out_tid,
  output logic [N_CH-1:0]        ch_aempty,
  output logic [N_CH*CW-1:0]     ch_pkt_cnt,
  output logic [N_CH-1:0]        overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = DATA_W + USER_W + 1;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic lock, found;
  logic [ID_W-1:0] grant, rr, pick;
  logic [N_CH-1:0] elig, nonempty, pop;
  logic [EW-1:0] heads [N_CH];
  assign lock = state == LOCK;
  assign out_tvalid = lock & nonempty[grant];
  assign {out_tlast, out_tuser, out_tdata} = lock ? heads[grant] : '0;
  assign out_tid = lock ? grant : '0;
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] beat;
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt, pcnt, occ;
    logic v, wr, ovf;
    assign occ = cnt + CW'(v);
    // the registered beat is already committed, so a full FIFO can only drop and flag it
    assign wr = v & (cnt != CW'(DEPTH));
    assign heads[c] = mem[rp];
    assign nonempty[c] = cnt != '0;
    assign elig[c] = STORE_FWD ? (pcnt != '0) : nonempty[c];
    assign pop[c] = lock & (grant == ID_W'(c)) & nonempty[c] & out_tready;
    assign in_tready[c] = ~rst & (occ < CW'(DEPTH - AFULL_VAL));
    assign ch_aempty[c] = occ <= CW'(AEMPTY_VAL);
    assign ch_pkt_cnt[c*CW +: CW] = pcnt;
    assign overflow[c] = ovf;
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= 1'b0;
        beat <= '0;
        wp <= '0;
        rp <= '0;
        cnt <= '0;
        pcnt <= '0;
        ovf <= 1'b0;
      end else begin
        v <= in_tvalid[c] & in_tready[c];
        beat <= {in_tlast[c], in_tuser[c*USER_W +: USER_W], in_tdata[c*DATA_W +: DATA_W]};
        ovf <= ovf | (v & ~wr);
        wp <= wp + PW'(wr);
        rp <= rp + PW'(pop[c]);
        cnt <= cnt + CW'(wr) - CW'(pop[c]);
        pcnt <= pcnt + CW'(wr & beat[EW-1]) - CW'(pop[c] & heads[c][EW-1]);
      end
    end
    always_ff @(posedge clk) if (wr) mem[wp] <= beat;
  end
  // search order starts just after the last packet's channel
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 1; i <= N_CH; i++)
      for (int j = 0; j < N_CH; j++)
        if (!found && elig[j] && (int'(rr) + i) % N_CH == j) begin
          pick = ID_W'(j);
          found = 1'b1;
        end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr <= ID_W'(N_CH - 1);
    end else if (!lock) begin
      if (found) begin
        grant <= pick;
        state <= LOCK;
      end
    end else if (out_tvalid & out_tready & out_tlast) begin
      rr <= grant;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cr_axi4s_slv_mc.sv
// tb_cr_axi4s_slv_mc: scoreboard bench for the multi-channel ingress buffer,
// plus a store-and-forward instance driven by a directed sequence.
module tb_cr_axi4s_slv_mc;
  localparam int N = 4, DW = 64, UW = 8, D = 16, AF = 2, AE = 1, CW = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] in_tvalid = '0, in_tlast = '0, in_tready, ch_aempty, overflow;
  logic [N*DW-1:0] in_tdata = '0;
  logic [N*UW-1:0] in_tuser = '0;
  logic out_tvalid, out_tready = 1'b0, out_tlast;
  logic [DW-1:0] out_tdata;
  logic [UW-1:0] out_tuser;
  logic [1:0] out_tid;
  logic [N*CW-1:0] ch_pkt_cnt;
  logic [N-1:0] sf_in_tvalid = '0, sf_in_tlast = '0, sf_in_tready, sf_ch_aempty, sf_overflow;
  logic [N*DW-1:0] sf_in_tdata = '0;
  logic [N*UW-1:0] sf_in_tuser = '0;
  logic sf_out_tvalid, sf_out_tready = 1'b0, sf_out_tlast;
  logic [DW-1:0] sf_out_tdata;
  logic [UW-1:0] sf_out_tuser;
  logic [1:0] sf_out_tid;
  logic [N*CW-1:0] sf_ch_pkt_cnt;
  always #5 clk = ~clk;
  cr_axi4s_slv_mc #(.N_CH(N), .DATA_W(DW), .USER_W(UW), .DEPTH(D), .AFULL_VAL(AF),
    .AEMPTY_VAL(AE), .STORE_FWD(1'b0)) dut (
    .clk(clk), .rst(rst), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_tuser(in_tuser), .in_tlast(in_tlast), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tdata(out_tdata), .out_tuser(out_tuser), .out_tlast(out_tlast), .out_tid(out_tid),
    .ch_aempty(ch_aempty), .ch_pkt_cnt(ch_pkt_cnt), .overflow(overflow));
  cr_axi4s_slv_mc #(.N_CH(N), .DATA_W(DW), .USER_W(UW), .DEPTH(D), .AFULL_VAL(AF),
    .AEMPTY_VAL(AE), .STORE_FWD(1'b1)) dut_sf (
    .clk(clk), .rst(rst), .in_tvalid(sf_in_tvalid), .in_tready(sf_in_tready), .in_tdata(sf_in_tdata),
    .in_tuser(sf_in_tuser), .in_tlast(sf_in_tlast), .out_tvalid(sf_out_tvalid), .out_tready(sf_out_tready),
    .out_tdata(sf_out_tdata), .out_tuser(sf_out_tuser), .out_tlast(sf_out_tlast), .out_tid(sf_out_tid),
    .ch_aempty(sf_ch_aempty), .ch_pkt_cnt(sf_ch_pkt_cnt), .overflow(sf_overflow));
  int n_chk = 0, n_err = 0;
  logic [DW+UW:0] exp_q [N][$];
  int occ_m [N], pkt_m [N], acc_n [N];
  logic [N-1:0] pend_l;
  int cur_tid, cyc;
  int ptid [$], pcyc [$];
  int sf_tid [$];
  logic [DW-1:0] sf_dat [$];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  // one clock of dut: check against the model, drive, then account for the coming edge
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy,
                      input logic [63:0] d = '1);
    logic [N-1:0] acc;
    logic [DW+UW:0] b;
    int t;
    @(negedge clk);
    cyc++;
    for (int c = 0; c < N; c++) begin
      chk("in_tready", 64'(in_tready[c]), 64'(occ_m[c] < D - AF));
      chk("ch_aempty", 64'(ch_aempty[c]), 64'(occ_m[c] <= AE));
      chk("ch_pkt_cnt", 64'(ch_pkt_cnt[c*CW +: CW]), 64'(pkt_m[c]));
      chk("overflow", 64'(overflow[c]), 64'(0));
    end
    for (int c = 0; c < N; c++) begin
      in_tdata[c*DW +: DW] = (d === '1) ? {$urandom, $urandom} : d;
      in_tuser[c*UW +: UW] = UW'($urandom);
    end
    in_tvalid = v;
    in_tlast = l;
    out_tready = ordy;
    acc = in_tvalid & in_tready;
    if (out_tvalid && out_tready) begin
      t = int'(out_tid);
      ptid.push_back(t);
      pcyc.push_back(cyc);
      if (cur_tid >= 0) chk("tid_lock", 64'(out_tid), 64'(cur_tid));
      if (exp_q[t].size() == 0) chk("pop_empty", 64'(1), 64'(0));
      else begin
        b = exp_q[t].pop_front();
        chk("out_tdata", out_tdata, b[DW-1:0]);
        chk("out_tuser_last", 64'({out_tlast, out_tuser}), 64'(b[DW+UW:DW]));
      end
      occ_m[t]--;
      if (out_tlast) pkt_m[t]--;
      cur_tid = out_tlast ? -1 : t;
    end
    for (int c = 0; c < N; c++) begin
      pkt_m[c] += int'(pend_l[c]);
      if (acc[c]) begin
        exp_q[c].push_back({l[c], in_tuser[c*UW +: UW], in_tdata[c*DW +: DW]});
        occ_m[c]++;
        acc_n[c]++;
      end
    end
    pend_l = acc & l;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_tvalid = '0;
    in_tlast = '0;
    out_tready = 1'b0;
    sf_in_tvalid = '0;
    sf_in_tlast = '0;
    sf_out_tready = 1'b0;
    @(negedge clk);
    chk("rst_in_tready", 64'(in_tready), 64'(0));
    chk("rst_out_tvalid", 64'(out_tvalid), 64'(0));
    chk("rst_aempty", 64'(ch_aempty), 64'hf);
    chk("rst_pkt_cnt", 64'(ch_pkt_cnt), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    for (int c = 0; c < N; c++) begin
      exp_q[c].delete();
      occ_m[c] = 0;
      pkt_m[c] = 0;
      acc_n[c] = 0;
    end
    pend_l = '0;
    cur_tid = -1;
    ptid.delete();
    pcyc.delete();
  endtask
  task automatic sf_rec();
    if (sf_out_tvalid && sf_out_tready) begin
      sf_tid.push_back(int'(sf_out_tid));
      sf_dat.push_back(sf_out_tdata);
    end
  endtask
  initial begin
    int a;
    cyc = 0;
    // single beat latency
    do_reset();
    step(4'h1, 4'h1, 1'b1, 64'hA5);
    step(4'h0, 4'h0, 1'b1);
    chk("lat_t1_valid", 64'(out_tvalid), 64'(0));
    step(4'h0, 4'h0, 1'b1);
    chk("lat_t2_valid", 64'(out_tvalid), 64'(0));
    step(4'h0, 4'h0, 1'b1);
    chk("lat_t3_valid", 64'(out_tvalid), 64'(1));
    chk("lat_t3_tid", 64'(out_tid), 64'(0));
    chk("lat_t3_data", out_tdata, 64'hA5);
    // almost-full backpressure on ch1
    do_reset();
    repeat (20) step(4'h2, 4'h0, 1'b0);
    chk("fill_accepts", 64'(acc_n[1]), 64'(D - AF));
    chk("fill_overflow", 64'(overflow), 64'(0));
    repeat (30) step(4'h0, 4'h0, 1'b1);
    chk("fill_drained", 64'(exp_q[1].size()), 64'(0));
    // round robin across four queued 3-beat packets
    do_reset();
    for (int i = 0; i < 3; i++) step(4'hf, (i == 2) ? 4'hf : 4'h0, 1'b0);
    repeat (30) step(4'h0, 4'h0, 1'b1);
    chk("rr_pops", 64'(ptid.size()), 64'(12));
    for (int k = 0; k < 12 && k < ptid.size(); k++) begin
      chk("rr_order", 64'(ptid[k]), 64'(k / 3));
      if (k > 0) chk("rr_gap", 64'(pcyc[k] - pcyc[k-1]), (k % 3 == 0) ? 64'(2) : 64'(1));
    end
    // simultaneous push and pop on ch0 at occupancy 5
    do_reset();
    repeat (5) step(4'h1, 4'h0, 1'b0);
    repeat (3) step(4'h0, 4'h0, 1'b0);
    step(4'h1, 4'h1, 1'b1);
    step(4'h0, 4'h0, 1'b0);
    step(4'h0, 4'h0, 1'b0);
    chk("pp_pkt_cnt", 64'(ch_pkt_cnt[CW-1:0]), 64'(1));
    a = acc_n[0];
    repeat (15) step(4'h1, 4'h0, 1'b0);
    chk("pp_room", 64'(acc_n[0] - a), 64'(D - AF - 5));
    repeat (30) step(4'h0, 4'h0, 1'b1);
    chk("pp_drained", 64'(exp_q[0].size()), 64'(0));
    // reset mid-packet while ch1 is granted
    do_reset();
    repeat (3) step(4'h2, 4'h0, 1'b0);
    repeat (2) step(4'h0, 4'h0, 1'b0);
    chk("mid_valid", 64'(out_tvalid), 64'(1));
    chk("mid_tid", 64'(out_tid), 64'(1));
    do_reset();
    step(4'h3, 4'h3, 1'b1);
    repeat (6) step(4'h0, 4'h0, 1'b1);
    chk("mid_next_tid", (ptid.size() > 0) ? 64'(ptid[0]) : 64'hdead, 64'(0));
    chk("mid_pops", 64'(ptid.size()), 64'(2));
    // randomized traffic against the scoreboard, then a flush with tlast beats
    do_reset();
    repeat (1500) step(N'($urandom), N'($urandom & $urandom), $urandom_range(0, 3) != 0);
    repeat (200) step(4'hf, 4'hf, 1'b1);
    repeat (150) step(4'h0, 4'h0, 1'b1);
    for (int c = 0; c < N; c++) chk("rand_drained", 64'(exp_q[c].size()), 64'(0));
    // store-and-forward: ch3 complete packet overtakes ch2 partial packet
    do_reset();
    @(negedge clk);
    sf_out_tready = 1'b1;
    sf_in_tvalid = 4'b1100;
    sf_in_tdata[2*DW +: DW] = 64'h20;
    sf_in_tdata[3*DW +: DW] = 64'h30;
    @(negedge clk);
    sf_in_tlast = 4'b1000;
    sf_in_tdata[2*DW +: DW] = 64'h21;
    sf_in_tdata[3*DW +: DW] = 64'h31;
    @(negedge clk);
    sf_in_tvalid = '0;
    sf_in_tlast = '0;
    repeat (10) begin
      @(negedge clk);
      chk("sf_pkt2_zero", 64'(sf_ch_pkt_cnt[2*CW +: CW]), 64'(0));
      sf_rec();
    end
    @(negedge clk);
    sf_rec();
    sf_in_tvalid = 4'b0100;
    sf_in_tlast = 4'b0100;
    sf_in_tdata[2*DW +: DW] = 64'h22;
    @(negedge clk);
    sf_rec();
    sf_in_tvalid = '0;
    sf_in_tlast = '0;
    @(negedge clk);
    chk("sf_pkt2_one", 64'(sf_ch_pkt_cnt[2*CW +: CW]), 64'(1));
    sf_rec();
    repeat (8) begin
      @(negedge clk);
      sf_rec();
    end
    chk("sf_pops", 64'(sf_tid.size()), 64'(5));
    for (int k = 0; k < 5 && k < sf_tid.size(); k++) begin
      chk("sf_tid", 64'(sf_tid[k]), (k < 2) ? 64'(3) : 64'(2));
      chk("sf_data", sf_dat[k], (k < 2) ? 64'(64'h30 + k) : 64'(64'h20 + k - 2));
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cr_axi4s_slv_mc.md
Name: cr_axi4s_slv_mc

Overview:
Multi-channel AXI4-Stream ingress buffer. It accepts N_CH independent AXI4-Stream slave inputs, registers each accepted beat into a per-channel FIFO, and merges the channels onto one AXI4-Stream master output. Merging uses a packet-granular round-robin arbiter, with optional store-and-forward per packet. It sits at the TLV-parser ingress, where several upstream stream sources share one downstream consumer.

Parameters:
N_CH, 4, number of input channels (1..16)
DATA_W, 64, tdata width
USER_W, 8, tuser width
DEPTH, 16, entries per channel FIFO (power of 2, >=4)
AFULL_VAL, 2, tready deasserts when occupancy >= DEPTH-AFULL_VAL (must be >=1)
AEMPTY_VAL, 1, per-channel aempty when occupancy <= AEMPTY_VAL
STORE_FWD, 0, 1 = a channel is eligible for grant only when it holds >=1 complete packet
ID_W, $clog2(N_CH) (min 1), derived width of out_tid

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_tvalid  in  N_CH  per-channel valid
in_tready  out  N_CH  per-channel ready
in_tdata  in  N_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
in_tuser  in  N_CH*USER_W  channel c at [c*USER_W +: USER_W]
in_tlast  in  N_CH  end of packet
out_tvalid  out  1  output valid
out_tready  in  1  output ready
out_tdata  out  DATA_W  head beat of granted channel
out_tuser  out  USER_W  head tuser of granted channel
out_tlast  out  1  head tlast of granted channel
out_tid  out  ID_W  granted channel index
ch_aempty  out  N_CH  per-channel almost empty
ch_pkt_cnt  out  N_CH*$clog2(DEPTH+1)  complete packets held per channel
overflow  out  N_CH  sticky per-channel write-into-full flag

Behaviour:
- One clock domain: clk. Reset: rst, synchronous, active-high.
- Reset: FIFOs empty, occupancy and packet counts 0, arbiter in IDLE, rr pointer = N_CH-1 (first grant goes to ch0), overflow = 0, out_tvalid = 0, ch_aempty = all 1.
- While rst is high, in_tready = 0. Reset asserted mid-packet drops all stored beats and any in-flight registered beat. A partially granted packet is abandoned.
- Ingress, per channel c:
  - Accept when in_tvalid[c] & in_tready[c].
  - The beat (data, user, last) is registered and written to FIFO c on the next cycle, so write latency is 1.
  - Occupancy counts the registered in-flight beat.
  - in_tready[c] = ~rst & (occ[c] < DEPTH-AFULL_VAL). It is a combinational function of registered state only; there is no same-cycle pop bypass.
- A write arriving with the FIFO full (unreachable when AFULL_VAL>=1) sets overflow[c] and is discarded. overflow clears only on rst.
- Simultaneous write and pop on one channel: occupancy unchanged.
- ch_pkt_cnt[c]: +1 on a write with tlast, -1 on a pop with tlast; both in the same cycle leaves it unchanged.
- Eligibility: STORE_FWD=0 requires FIFO c non-empty. STORE_FWD=1 requires ch_pkt_cnt[c] > 0.
- Arbiter FSM:
  - IDLE: out_tvalid = 0. If any channel is eligible, register grant = first eligible channel searching from rr+1 upward with wrap, then go to LOCK. One bubble cycle occurs per packet.
  - LOCK: out_tvalid = FIFO[grant] non-empty, and out_t* show the head of that FIFO. Pop on out_tvalid & out_tready.
  - LOCK exit: a pop with tlast=1 sets rr <= grant and returns to IDLE. Otherwise stay in LOCK; the grant holds until tlast even if the FIFO goes empty.
- Output holds stable while out_tvalid=1 and out_tready=0.
- out_tdata, out_tuser, out_tlast and out_tid are don't-care when out_tvalid=0. Drive them as 0 in IDLE.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is $clog2(DEPTH+1) bits.

Test Plan:
- Single beat ch0, DATA=0xA5, tlast=1, out_tready=1: in_tready high at reset release; accept at cycle t; FIFO write at t+1; grant at t+2; out_tvalid=1, tid=0 at t+3.
- DEPTH=16, AFULL_VAL=2, out_tready=0, ch1 streaming continuously: in_tready[1] falls after 14 accepts; occupancy 14; overflow=0; no beat lost after release.
- Four channels, each with a 3-beat packet queued, out_tready=1: output order tid 0,1,2,3; packets are not interleaved; one idle cycle between packets.
- STORE_FWD=1, ch2 sends 2 beats without tlast, ch3 sends a complete packet: ch3 is forwarded first; ch2 is granted only after its tlast is written; ch_pkt_cnt[2] reads 0 then 1.
- Simultaneous push and pop on ch0 at occupancy 5: occupancy stays 5; a tlast push combined with a non-last pop gives pkt_cnt +1.
- rst pulsed mid-packet, with ch1 granted and 3 beats stored: after rst, out_tvalid=0, ch_aempty=all 1, pkt_cnt=0, next grant goes to ch0.
